// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enables one oscillator, lets it settle,
// counts synchronized rising edges over a programmed window, then holds the result until ack.
//
// state  | meaning
// IDLE   | waiting for start; sel/win_len latched on start
// SETTLE | selected oscillator enabled, settle timer running
// MEAS   | oscillator enabled, counting edges, window timer running
// HOLD   | oscillator off, result presented on valid until ack
module ro_meas_ctrl #(
  parameter int N_RO       = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int SEL_W      = (N_RO > 1) ? $clog2(N_RO) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N_RO-1:0]  ro_in,
  output logic [N_RO-1:0]  ro_en,
  output logic             busy,
  output logic             valid,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SETTLE, MEAS, HOLD} state_t;

  localparam int               SET_W    = $clog2(SETTLE_CYC);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W:0]   N_RO_X   = (SEL_W + 1)'(N_RO);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_src;
  logic [SET_W-1:0] settle_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [N_RO-1:0]  ro_meta, ro_sync, ro_prev, ro_en_nxt;
  logic             sel_bad, edge_det;

  assign sel_bad = ({1'b0, sel} >= N_RO_X);
  assign busy    = (state != IDLE);
  assign valid   = (state == HOLD);

  // Explicit compare mux keeps an out-of-range latched select from indexing past N_RO.
  always_comb begin
    edge_det = 1'b0;
    for (int i = 0; i < N_RO; i++) begin
      if (sel_q == SEL_W'(i)) edge_det = ro_sync[i] & ~ro_prev[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = sel_bad ? HOLD : SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = (win_cnt == '0) ? HOLD : MEAS;
      MEAS:    if (win_cnt == WIN_W'(1)) state_nxt = HOLD;
      HOLD:    if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enable is decoded from the next state so the registered ro_en tracks the FSM exactly.
  always_comb begin
    sel_src   = (state == IDLE) ? sel : sel_q;
    ro_en_nxt = '0;
    if (state_nxt == SETTLE || state_nxt == MEAS) begin
      for (int i = 0; i < N_RO; i++) ro_en_nxt[i] = (sel_src == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ro_en      <= '0;
      sel_q      <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      ro_meta    <= '0;
      ro_sync    <= '0;
      ro_prev    <= '0;
    end else begin
      state   <= state_nxt;
      ro_en   <= ro_en_nxt;
      ro_meta <= ro_in;
      ro_sync <= ro_meta;
      ro_prev <= ro_sync;
      case (state)
        IDLE: begin
          if (start) begin
            sel_q      <= sel;
            win_cnt    <= win_len;
            settle_cnt <= SET_LOAD;
            count      <= '0;
            ovf        <= 1'b0;
            err        <= sel_bad;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        end
        MEAS: begin
          win_cnt <= win_cnt - WIN_W'(1);
          // ovf flags an edge that arrived while the count was already pinned at all-ones.
          if (edge_det) begin
            if (count == '1) ovf <= 1'b1;
            else             count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Bench for ro_meas_ctrl: directed measurements on two instances (N_RO=4/CNT_W=16 and
// N_RO=3/CNT_W=4) with expectations queued at launch and checked by a negedge monitor.
module tb_ro_meas_ctrl;
  localparam int S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0 = 1'b1, start0 = 1'b0, ack0 = 1'b1;
  logic [1:0]  sel0 = '0;
  logic [15:0] win0 = '0;
  logic [3:0]  ro_in0, ro_en0;
  logic        busy0, valid0, ovf0, err0;
  logic [15:0] count0;

  logic        rst1 = 1'b1, start1 = 1'b0, ack1 = 1'b0;
  logic [1:0]  sel1 = '0;
  logic [15:0] win1 = '0;
  logic [2:0]  ro_in1, ro_en1;
  logic        busy1, valid1, ovf1, err1;
  logic [3:0]  count1;

  logic ro2 = 1'b0, ro3 = 1'b0;
  assign ro_in0 = {ro3, ro2, 1'b0, 1'b1};
  assign ro_in1 = {ro2, 1'b0, 1'b1};

  ro_meas_ctrl #(.N_RO(4), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .sel(sel0), .win_len(win0), .ro_in(ro_in0),
    .ro_en(ro_en0), .busy(busy0), .valid(valid0), .ack(ack0), .count(count0),
    .ovf(ovf0), .err(err0));

  ro_meas_ctrl #(.N_RO(3), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .sel(sel1), .win_len(win1), .ro_in(ro_in1),
    .ro_en(ro_en1), .busy(busy1), .valid(valid1), .ack(ack1), .count(count1),
    .ovf(ovf1), .err(err1));

  // Oscillators: period 8 clk on ro2, period 16 on ro3, phase offset from clk edges.
  initial begin #3; forever #40 ro2 = ~ro2; end
  initial begin #3; forever #80 ro3 = ~ro3; end

  // dut1 consumer acknowledges in the fifth cycle of valid.
  int h1 = 0;
  initial forever begin
    @(negedge clk);
    if (valid1) h1++; else h1 = 0;
    ack1 = (h1 == 5);
  end

  typedef struct {
    int unsigned vcyc;
    logic [15:0] cnt;
    logic        ovf;
    logic        err;
    int unsigned en_cyc;
    logic [3:0]  en_or;
    int unsigned width;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input int d, input int s, input int w, input int unsigned t,
                          input int ecnt, input bit eovf);
    exp_t e;
    e.err    = (s >= ((d == 0) ? 4 : 3));
    e.vcyc   = e.err ? t : t + S + w;
    e.cnt    = 16'(ecnt);
    e.ovf    = eovf;
    e.en_cyc = e.err ? 0 : S + w;
    e.en_or  = e.err ? 4'b0 : 4'(1 << s);
    e.width  = (d == 0) ? 1 : 5;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic launch(input int d, input int s, input int w, input bit push,
                        input int ecnt, input bit eovf, output int unsigned t);
    @(negedge clk);
    if (d == 0) begin start0 = 1'b1; sel0 = 2'(s); win0 = 16'(w); end
    else        begin start1 = 1'b1; sel1 = 2'(s); win1 = 16'(w); end
    t = cyc + 1;
    if (push) push_exp(d, s, w, t, ecnt, eovf);
    @(negedge clk);
    // Scramble inputs after latching; they must not affect the running measurement.
    if (d == 0) begin start0 = 1'b0; sel0 = 2'(s ^ 1); win0 = 16'(w ^ 'h55); end
    else        begin start1 = 1'b0; sel1 = 2'(s ^ 1); win1 = 16'(w ^ 'h55); end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int   k = 0;
    logic b;
    do begin
      @(negedge clk);
      k++;
      b = (d == 0) ? busy0 : busy1;
    end while (b && k < budget);
    chk($sformatf("d%0d_idle_timeout", d), b, 0);
  endtask

  // Monitor state, indexed by instance.
  logic        s_valid[2], p_valid[2], s_busy[2], s_ovf[2], s_err[2];
  logic [15:0] s_cnt[2], r_cnt[2];
  logic [3:0]  s_en[2], en_or[2];
  logic        r_ovf[2], r_err[2];
  int unsigned r_cyc[2], vlen[2], en_cyc[2];
  bit          multi[2], stray[2], hbad[2];

  task automatic mon_step(input int d);
    exp_t e;
    bit   have;
    if (s_valid[d] && !p_valid[d]) begin
      r_cyc[d] = cyc; r_cnt[d] = s_cnt[d]; r_ovf[d] = s_ovf[d]; r_err[d] = s_err[d];
      vlen[d] = 1;
      hbad[d] = (!s_busy[d] || s_en[d] != 0);
    end else if (s_valid[d]) begin
      vlen[d]++;
      if (s_cnt[d] != r_cnt[d] || s_ovf[d] != r_ovf[d] || s_err[d] != r_err[d] ||
          s_en[d] != 0 || !s_busy[d]) hbad[d] = 1;
    end else if (p_valid[d]) begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        n_tests++;
        n_fail++;
        $display("FAIL d%0d_unexpected_valid: valid at cycle %0d, none pending", d, r_cyc[d]);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("d%0d_valid_cycle", d), r_cyc[d], e.vcyc);
        chk($sformatf("d%0d_count", d), r_cnt[d], e.cnt);
        chk($sformatf("d%0d_ovf", d), r_ovf[d], e.ovf);
        chk($sformatf("d%0d_err", d), r_err[d], e.err);
        chk($sformatf("d%0d_en_cycles", d), en_cyc[d], e.en_cyc);
        chk($sformatf("d%0d_en_bits", d), en_or[d], e.en_or);
        chk($sformatf("d%0d_valid_width", d), vlen[d], e.width);
        chk($sformatf("d%0d_hold_stable", d), hbad[d], 0);
        chk($sformatf("d%0d_en_onehot", d), multi[d], 0);
        chk($sformatf("d%0d_en_idle", d), stray[d], 0);
        stray[d] = 0;
      end
    end
    if (s_busy[d] && !s_valid[d]) begin
      if (s_en[d] != 0) en_cyc[d]++;
      en_or[d] = en_or[d] | s_en[d];
      if (!$onehot0(s_en[d])) multi[d] = 1;
    end
    if (!s_busy[d]) begin
      if (s_en[d] != 0) stray[d] = 1;
      en_cyc[d] = 0; en_or[d] = '0; multi[d] = 0;
    end
    p_valid[d] = s_valid[d];
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      p_valid[d] = 0; en_cyc[d] = 0; en_or[d] = '0; vlen[d] = 0;
      multi[d] = 0; stray[d] = 0; hbad[d] = 0;
    end
    forever begin
      @(negedge clk);
      s_valid[0] = valid0; s_busy[0] = busy0; s_ovf[0] = ovf0; s_err[0] = err0;
      s_cnt[0] = count0;   s_en[0] = ro_en0;
      s_valid[1] = valid1; s_busy[1] = busy1; s_ovf[1] = ovf1; s_err[1] = err1;
      s_cnt[1] = {12'b0, count1}; s_en[1] = {1'b0, ro_en1};
      for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, v;
    int          k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0", busy0, 0);   chk("rst_valid0", valid0, 0); chk("rst_en0", ro_en0, 0);
    chk("rst_count0", count0, 0); chk("rst_ovf0", ovf0, 0);     chk("rst_err0", err0, 0);
    chk("rst_busy1", busy1, 0);   chk("rst_valid1", valid1, 0); chk("rst_en1", ro_en1, 0);
    chk("rst_count1", count1, 0); chk("rst_ovf1", ovf1, 0);     chk("rst_err1", err1, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy0", busy0, 0);
    chk("post_rst_en0", ro_en0, 0);

    fork
      begin
        launch(0, 2, 80, 1, 10, 0, t); wait_idle(0, 200);
        launch(0, 3, 80, 1, 5, 0, t);  wait_idle(0, 200);
        launch(0, 1, 40, 1, 0, 0, t);  wait_idle(0, 200);
        launch(0, 1, 0, 1, 0, 0, t);   wait_idle(0, 200);
        // Start pulses in MEAS and in the ack cycle are ignored; start at A+1 relaunches.
        launch(0, 2, 16, 1, 2, 0, t);
        repeat (S + 4) @(negedge clk);
        start0 = 1'b1; sel0 = 2'd3; win0 = 16'd16;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (!valid0 && k < 100) begin @(negedge clk); k++; end
        chk("d0_hs_valid_seen", valid0, 1);
        v = cyc;
        push_exp(0, 3, 16, v + 2, 1, 0);
        start0 = 1'b1;
        repeat (2) @(negedge clk);
        start0 = 1'b0;
        wait_idle(0, 200);
        // Reset in the 30th cycle of an 80-cycle window.
        launch(0, 2, 80, 0, 0, 0, t);
        while (cyc != t + S + 29) @(negedge clk);
        chk("d0_pre_rst_en", ro_en0, 4'b0100);
        chk("d0_pre_rst_busy", busy0, 1);
        rst0 = 1'b1;
        #1;
        chk("d0_rst_en_async", ro_en0, 0);
        chk("d0_rst_valid_async", valid0, 0);
        chk("d0_rst_busy_async", busy0, 0);
        @(negedge clk);
        rst0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("d0_after_rst_busy", busy0, 0);
        chk("d0_after_rst_count", count0, 0);
        chk("d0_after_rst_en", ro_en0, 0);
        launch(0, 2, 8, 1, 1, 0, t);   wait_idle(0, 200);
      end
      begin
        launch(1, 2, 112, 1, 14, 0, t); wait_idle(1, 300);
        launch(1, 2, 200, 1, 15, 1, t); wait_idle(1, 300);
        launch(1, 3, 50, 1, 0, 0, t);   wait_idle(1, 300);
        launch(1, 0, 16, 1, 0, 0, t);   wait_idle(1, 300);
      end
    join

    repeat (5) @(negedge clk);
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
